// File: rtl/fwrisc_ifetch_pf.sv
// Instruction prefetch buffer between the fwrisc core fetch port and a
// single-outstanding-request memory port; ENABLE_PF=0 gives a pure passthrough.
module fwrisc_ifetch_pf #(
  parameter int DEPTH     = 4,
  parameter int ENABLE_PF = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iaddr,
  input  logic        ivalid,
  output logic        iready,
  output logic [31:0] idata,
  input  logic        flush,
  output logic [31:0] maddr,
  output logic        mvalid,
  input  logic [31:0] mdata,
  input  logic        mready
);

  generate
    if (ENABLE_PF == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = &{1'b0, clock, reset, flush, iaddr[1:0]};
      assign maddr  = {iaddr[31:2], 2'b00};
      assign mvalid = ivalid;
      assign iready = mready;
      assign idata  = mdata;
    end else begin : g_pf
      localparam int AW = $clog2(DEPTH);
      localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

      typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DISCARD = 2'd2} state_t;

      state_t        state;
      logic [31:0]   q_data [DEPTH];
      logic [AW-1:0] rd_ptr;
      logic [AW:0]   count;
      logic [31:0]   head_addr;
      logic [31:0]   fetch_addr;
      logic [31:0]   mreq_addr;
      logic          mreq_valid;

      logic          hit;
      logic          own;
      logic          bypass;
      logic          miss;
      logic          done;
      logic          push;
      logic [AW:0]   count_n;
      logic [AW-1:0] wr_ptr;
      logic [31:0]   iaddr_w;
      logic          unused_pf;

      assign unused_pf = &{1'b0, iaddr[1:0]};

      // own: the outstanding request is already for the core's address, so wait for it
      always_comb begin
        iaddr_w = {iaddr[31:2], 2'b00};
        hit     = ivalid && (count != '0) && (iaddr[31:2] == head_addr[31:2]);
        own     = ivalid && !hit && (state == STREAM) && mreq_valid &&
                  (iaddr[31:2] == mreq_addr[31:2]);
        bypass  = own && mready;
        miss    = ivalid && !hit && !own && (state != DISCARD);
        done    = mreq_valid && mready;
        push    = (state == STREAM) && done && !bypass;
        wr_ptr  = rd_ptr + count[AW-1:0];
        count_n = count - {{AW{1'b0}}, hit} + {{AW{1'b0}}, push};
      end

      always_comb begin
        iready = hit || bypass;
        if (hit) begin
          idata = q_data[rd_ptr];
        end else if (bypass) begin
          idata = mdata;
        end else begin
          idata = 32'h0000_0000;
        end
      end

      assign mvalid = mreq_valid;
      assign maddr  = mreq_addr;

      // Entries written after a flush or miss are dead because count is cleared
      always_ff @(posedge clock) begin
        if (push) begin
          q_data[wr_ptr] <= mdata;
        end
      end

      always_ff @(posedge clock) begin
        if (!reset) begin
          state      <= IDLE;
          mreq_valid <= 1'b0;
          mreq_addr  <= 32'h0000_0000;
          count      <= '0;
          rd_ptr     <= '0;
          head_addr  <= 32'h0000_0000;
          fetch_addr <= 32'h0000_0000;
        end else if (flush) begin
          count <= '0;
          if (mreq_valid && !mready) begin
            state <= DISCARD;
          end else begin
            state      <= IDLE;
            mreq_valid <= 1'b0;
          end
        end else begin
          case (state)
            IDLE: begin
              if (miss) begin
                state      <= STREAM;
                mreq_valid <= 1'b1;
                mreq_addr  <= iaddr_w;
                fetch_addr <= iaddr_w + 32'd4;
                head_addr  <= iaddr_w;
                count      <= '0;
              end
            end
            DISCARD: begin
              if (mready) begin
                if (ivalid) begin
                  state      <= STREAM;
                  mreq_valid <= 1'b1;
                  mreq_addr  <= iaddr_w;
                  fetch_addr <= iaddr_w + 32'd4;
                  head_addr  <= iaddr_w;
                  count      <= '0;
                end else begin
                  state      <= IDLE;
                  mreq_valid <= 1'b0;
                end
              end
            end
            STREAM: begin
              if (miss) begin
                count <= '0;
                if (mreq_valid && !mready) begin
                  state <= DISCARD;
                end else begin
                  mreq_valid <= 1'b1;
                  mreq_addr  <= iaddr_w;
                  fetch_addr <= iaddr_w + 32'd4;
                  head_addr  <= iaddr_w;
                end
              end else if (own && !mready) begin
                // core skipped ahead onto the in-flight word: older entries are dead
                count     <= '0;
                head_addr <= iaddr_w;
              end else begin
                count <= count_n;
                if (hit) begin
                  rd_ptr    <= rd_ptr + 1'b1;
                  head_addr <= head_addr + 32'd4;
                end else if (bypass) begin
                  head_addr <= mreq_addr + 32'd4;
                end
                if (!mreq_valid || mready) begin
                  if (count_n < DEPTH_C) begin
                    mreq_valid <= 1'b1;
                    mreq_addr  <= fetch_addr;
                    fetch_addr <= fetch_addr + 32'd4;
                  end else begin
                    mreq_valid <= 1'b0;
                  end
                end
              end
            end
            default: begin
              state      <= IDLE;
              mreq_valid <= 1'b0;
              count      <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fwrisc_ifetch_pf.sv
// Randomized self-checking bench for fwrisc_ifetch_pf: a queue-based reference
// model plus directed stream, discard, full, flush, wrap and passthrough cases.
`timescale 1ns/1ps
module tb_fwrisc_ifetch_pf;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, ivalid, iready, flush, mvalid, mready;
  logic [31:0] iaddr, idata, maddr, mdata;
  logic        p_ivalid, p_iready, p_mvalid, p_mready;
  logic [31:0] p_iaddr, p_idata, p_maddr, p_mdata;

  fwrisc_ifetch_pf #(.DEPTH(DEPTH), .ENABLE_PF(1)) dut (
    .clock(clock), .reset(reset), .iaddr(iaddr), .ivalid(ivalid), .iready(iready),
    .idata(idata), .flush(flush), .maddr(maddr), .mvalid(mvalid), .mdata(mdata),
    .mready(mready));

  fwrisc_ifetch_pf #(.DEPTH(DEPTH), .ENABLE_PF(0)) dut_pass (
    .clock(clock), .reset(reset), .iaddr(p_iaddr), .ivalid(p_ivalid), .iready(p_iready),
    .idata(p_idata), .flush(1'b0), .maddr(p_maddr), .mvalid(p_mvalid), .mdata(p_mdata),
    .mready(p_mready));

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] mq[$];
  logic        out_v = 1'b0, disc = 1'b0, streaming = 1'b0;
  logic [31:0] out_a = 32'h0, nxt = 32'h0;

  // memory and stimulus controls
  logic        mem_busy = 1'b0;
  int          mem_wait = 0;
  int          wmax = 0;
  int          wait_q[$];
  logic        rand_flush = 1'b0, flush_arm = 1'b0, chk_ahead = 1'b0;
  logic [31:0] flush_addr = 32'h0;
  logic        s_iready;
  logic [31:0] s_idata;

  typedef struct { logic mv; logic mr; logic [31:0] ma; } hist_t;
  hist_t hist[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic start_model(input logic [31:0] a);
    mq.delete();
    out_v = 1'b1; out_a = {a[31:2], 2'b00}; nxt = out_a + 32'd4;
    streaming = 1'b1; disc = 1'b0;
  endtask

  // one clock cycle: drive memory, compare at negedge, advance model at posedge
  task automatic step();
    logic m_hit, m_own, m_byp, m_miss, m_done;
    flush = rand_flush && ($urandom_range(0, 24) == 0);
    if (!reset) begin
      p_ivalid = 1'b0; p_iaddr = 32'h0; p_mready = 1'b0; p_mdata = 32'h0;
    end else begin
      p_ivalid = 1'($urandom_range(0, 1)); p_iaddr = $urandom();
      p_mready = ($urandom_range(0, 3) == 0); p_mdata = $urandom();
    end
    if (reset && mvalid && !mem_busy) begin
      mem_busy = 1'b1;
      if (wait_q.size() > 0) mem_wait = wait_q.pop_front();
      else mem_wait = $urandom_range(0, wmax);
    end
    mready = reset && mvalid && mem_busy && (mem_wait == 0);
    mdata  = mready ? memfn(maddr) : $urandom();
    if (flush_arm && mready && maddr[31:2] == flush_addr[31:2]) begin
      flush = 1'b1; flush_arm = 1'b0;
    end
    @(negedge clock);
    m_hit  = ivalid && (mq.size() > 0) && (iaddr[31:2] == mq[0][31:2]);
    m_own  = ivalid && !m_hit && !disc && out_v && (iaddr[31:2] == out_a[31:2]);
    m_byp  = m_own && mready;
    m_miss = ivalid && !m_hit && !m_own && !disc;
    m_done = out_v && mready;
    chk1("mvalid", mvalid, out_v);
    if (out_v) chk("maddr", maddr, out_a);
    chk1("iready", iready, m_hit || m_byp);
    if (m_hit) chk("idata_hit", idata, memfn(mq[0]));
    else if (m_byp) chk("idata_bypass", idata, memfn(out_a));
    if (chk_ahead && mvalid && ivalid)
      chk1("lookahead", (maddr - {iaddr[31:2], 2'b00}) <= 32'd16, 1'b1);
    chk("pass_maddr", p_maddr, {p_iaddr[31:2], 2'b00});
    chk1("pass_mvalid", p_mvalid, p_ivalid);
    chk1("pass_iready", p_iready, p_mready);
    chk("pass_idata", p_idata, p_mdata);
    hist.push_back('{mvalid, mready, maddr});
    s_iready = iready; s_idata = idata;
    @(posedge clock);
    if (!reset) begin
      mq.delete(); out_v = 1'b0; out_a = 32'h0; disc = 1'b0; streaming = 1'b0;
    end else if (flush) begin
      mq.delete(); streaming = 1'b0;
      if (out_v && !m_done) disc = 1'b1;
      else begin out_v = 1'b0; disc = 1'b0; end
    end else if (disc) begin
      if (m_done) begin
        disc = 1'b0;
        if (ivalid) start_model(iaddr); else out_v = 1'b0;
      end
    end else if (m_miss) begin
      mq.delete();
      if (out_v && !m_done) begin disc = 1'b1; streaming = 1'b0; end
      else start_model(iaddr);
    end else if (m_own && !m_byp) begin
      mq.delete();
    end else if (streaming) begin
      if (m_hit) void'(mq.pop_front());
      if (m_done) begin
        if (!m_byp) mq.push_back(out_a);
        out_v = 1'b0;
      end
      if (!out_v && mq.size() < DEPTH) begin
        out_v = 1'b1; out_a = nxt; nxt = nxt + 32'd4;
      end
    end
    if (!reset || mready) mem_busy = 1'b0;
    else if (mem_busy && mem_wait > 0) mem_wait--;
    #1;
  endtask

  task automatic idle(input int n);
    ivalid = 1'b0;
    repeat (n) step();
  endtask

  task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] d);
    ivalid = 1'b1; iaddr = a; lat = 0;
    do begin
      step(); lat++;
    end while (!s_iready && lat < 200);
    chk1("fetch_done", s_iready, 1'b1);
    d = s_idata; ivalid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; ivalid = 1'b0;
    repeat (n) step();
    chk1("rst_iready", iready, 1'b0);
    chk("rst_idata", idata, 32'h0);
    chk1("rst_mvalid", mvalid, 1'b0);
    chk("rst_maddr", maddr, 32'h0);
    chk("rst_pass_maddr", p_maddr, 32'h0);
    chk1("rst_pass_mvalid", p_mvalid, 1'b0);
    chk1("rst_pass_iready", p_iready, 1'b0);
    chk("rst_pass_idata", p_idata, 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, reads, found;
    logic [31:0] d, pc;
    logic [31:0] wexp [4];
    logic [31:0] rd[$];
    reset = 1'b0; ivalid = 1'b0; iaddr = 32'h0; flush = 1'b0;
    mready = 1'b0; mdata = 32'h0;
    p_ivalid = 1'b0; p_iaddr = 32'h0; p_mready = 1'b0; p_mdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    do_reset(2);

    // sequential stream with zero-wait memory
    chk_ahead = 1'b1;
    for (int k = 0; k < 12; k++) begin
      fetch(32'h100 + 32'(k * 4), lat, d);
      chk("stream_lat", 32'(lat), (k == 0) ? 32'd2 : 32'd1);
      chk("stream_data", d, memfn(32'h100 + 32'(k * 4)));
    end
    chk_ahead = 1'b0;

    // fill to full, then pop, then discard on branch
    do_reset(2);
    fetch(32'h1FC, lat, d);
    chk("miss_lat", 32'(lat), 32'd2);
    hist.delete();
    idle(8);
    reads = 0;
    foreach (hist[i]) if (hist[i].mr) reads++;
    chk("full_reads", 32'(reads), 32'd4);
    chk1("full_mvalid", mvalid, 1'b0);
    wait_q.push_back(3);
    fetch(32'h200, lat, d);
    chk("hit_lat", 32'(lat), 32'd1);
    chk("hit_data", d, memfn(32'h200));
    chk1("resume_mvalid", mvalid, 1'b1);
    chk("resume_maddr", maddr, 32'h210);
    hist.delete();
    fetch(32'h400, lat, d);
    chk("branch_data", d, memfn(32'h400));
    found = 0;
    for (int c = 0; c + 1 < hist.size(); c++)
      if (hist[c].mr && hist[c].ma == 32'h210) begin
        found = 1;
        chk1("redirect_mvalid", hist[c+1].mv, 1'b1);
        chk("redirect_maddr", hist[c+1].ma, 32'h400);
      end
    chk("discard_seen", 32'(found), 32'd1);

    // flush coincident with the mready of 0x30C
    do_reset(2);
    wait_q.push_back(0); wait_q.push_back(0); wait_q.push_back(0); wait_q.push_back(2);
    fetch(32'h300, lat, d);
    flush_arm = 1'b1; flush_addr = 32'h30C;
    idle(6);
    chk1("flush_fired", flush_arm, 1'b0);
    hist.delete();
    fetch(32'h30E, lat, d);
    chk("refetch_lat", 32'(lat), 32'd2);
    chk("refetch_data", d, memfn(32'h30C));
    found = 0;
    foreach (hist[i]) if (hist[i].mr && hist[i].ma == 32'h30C) found = 1;
    chk("refetch_seen", 32'(found), 32'd1);

    // address wrap-around
    do_reset(2);
    hist.delete();
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    for (int k = 0; k < 4; k++) begin
      fetch(wexp[k], lat, d);
      chk("wrap_lat", 32'(lat), (k == 0) ? 32'd2 : 32'd1);
      chk("wrap_data", d, memfn(wexp[k]));
    end
    foreach (hist[i]) if (hist[i].mr) rd.push_back(hist[i].ma);
    for (int k = 0; k < 4; k++)
      chk("wrap_maddr", (k < rd.size()) ? rd[k] : 32'hDEAD_BEEF, wexp[k]);

    // reset while a request is outstanding
    wait_q.push_back(10);
    idle(3);
    do_reset(2);

    // randomized traffic with wait states, branches, flushes and resets
    wmax = 3; rand_flush = 1'b1; pc = 32'h1000;
    for (int t = 0; t < 400; t++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10) idle($urandom_range(1, 5));
      else if (r < 22) pc = 32'h1000 + ($urandom_range(0, 31) << 2);
      else if (r < 24) do_reset(2);
      fetch(pc | 32'($urandom_range(0, 3)), lat, d);
      chk("rand_data", d, memfn(pc));
      pc = pc + 32'd4;
    end
    rand_flush = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
